// File: rtl/cfs_apb_pkg.sv
// Shared types and width limits for the CFS APB arbitrating master.
package cfs_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } cfs_apb_arb_state_t;

    localparam int CFS_APB_MAX_ADDR_WIDTH = 16;
    localparam int CFS_APB_MAX_DATA_WIDTH = 32;

endpackage

// File: rtl/cfs_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts just after the last
// granted index and wraps, so every requester is reached within N grants.
module cfs_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_grant_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o,
    output logic          any_o
);

    logic [IW-1:0] idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        idx         = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IW'((int'(last_grant_i) + k) % N);
            if (!any_o && req_i[idx]) begin
                any_o       = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o = idx;
            end
        end
    end

endmodule

// File: rtl/cfs_apb_arb_master.sv
// Shares one APB master port between NUM_REQ requesters with round-robin
// arbitration, SETUP/ACCESS sequencing and an ACCESS-phase timeout.
module cfs_apb_arb_master
    import cfs_apb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          pclk,
    input  logic                          preset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic                          psel,
    output logic                          penable,
    output logic                          pwrite,
    output logic [ADDR_WIDTH-1:0]         paddr,
    output logic [DATA_WIDTH-1:0]         pwdata,
    input  logic                          pready,
    input  logic                          pslverr,
    input  logic [DATA_WIDTH-1:0]         prdata
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    cfs_apb_arb_state_t state_q, state_d;

    logic [IW-1:0]         last_grant_q;
    logic [IW-1:0]         gidx_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  psel_q, penable_q, pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q, rdata_q;
    logic                  err_q;

    logic [NUM_REQ-1:0]    arb_grant;
    logic [IW-1:0]         arb_idx;
    logic                  arb_any;
    logic                  accept, timeout;
    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    cfs_rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .grant_idx_o  (arb_idx),
        .any_o        (arb_any)
    );

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign accept  = (state_q == IDLE) && arb_any;
    assign timeout = (cnt_d == CW'(TIMEOUT_CYCLES));

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        req_ready = '0;
        rsp_valid = '0;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    req_ready = arb_grant;
                    state_d   = SETUP;
                end
            end
            SETUP:  state_d = ACCESS;
            ACCESS: begin
                cnt_d = cnt_q + CW'(1);
                // A late pready on the final allowed cycle still wins over the timeout.
                if (pready || timeout) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid[gidx_q] = 1'b1;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            last_grant_q <= IW'(NUM_REQ - 1);
            gidx_q       <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            psel_q    <= (state_d == SETUP) || (state_d == ACCESS);
            penable_q <= (state_d == ACCESS);
            if (accept) begin
                last_grant_q <= arb_idx;
                gidx_q       <= arb_idx;
                pwrite_q     <= sel_write;
                paddr_q      <= sel_addr & ~ADDR_WIDTH'(3);
                pwdata_q     <= sel_wdata;
            end
            if (state_q == ACCESS) begin
                if (pready) begin
                    err_q   <= pslverr;
                    rdata_q <= pwrite_q ? '0 : prdata;
                end else if (timeout) begin
                    err_q   <= 1'b1;
                    rdata_q <= '0;
                end
            end
        end
    end

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
